// File: rtl/vend_sequencer.sv
// Vend sequencer: queues vend events from the credit FSM, runs the dispenser
// handshake, and pays change out as timed single-nickel strobes to the hopper.
module vend_sequencer #(
  parameter int DEPTH        = 4,
  parameter int CHG_W        = 3,
  parameter int PULSE_W      = 2,
  parameter int GAP_W        = 2,
  parameter int DISP_TIMEOUT = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_vend,
  input  logic [CHG_W-1:0]           i_change,
  input  logic                       i_disp_done,
  input  logic                       i_hopper_rdy,
  input  logic                       i_clr_fault,
  output logic                       o_disp_start,
  output logic                       o_nickel,
  output logic                       o_busy,
  output logic                       o_fault,
  output logic                       o_drop,
  output logic [$clog2(DEPTH+1)-1:0] o_pending
);

  localparam int PW   = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int TW   = $clog2(DISP_TIMEOUT + 1);
  localparam int PMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPENSE = 3'd1,
    S_PAYWAIT  = 3'd2,
    S_PAYHI    = 3'd3,
    S_PAYLO    = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CHG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    count_q, count_d;
  logic [CHG_W-1:0] chg_q, chg_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CW-1:0]    ph_q, ph_d;
  logic             disp_start_q, nickel_q, busy_q, fault_q, drop_q;
  logic             full_s, empty_s, pop_s, push_s, drop_s;

  assign full_s  = (count_q == PW'(DEPTH));
  assign empty_s = (count_q == {PW{1'b0}});
  // The FSM only pops on its way out of IDLE, so a full queue admits a push only then.
  assign pop_s   = (state_q == S_IDLE) && !empty_s;
  assign push_s  = i_vend && (!full_s || pop_s);
  assign drop_s  = i_vend && full_s && !pop_s;

  // Occupancy bookkeeping for the change FIFO.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next-state and counter logic for the dispense/payout sequence.
  always_comb begin
    state_d = state_q;
    chg_d   = chg_q;
    tmo_d   = tmo_q;
    ph_d    = ph_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = S_DISPENSE;
          chg_d   = mem_q[rd_ptr_q];
          tmo_d   = {TW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DISPENSE: begin
        if (i_disp_done) begin
          state_d = (chg_q == {CHG_W{1'b0}}) ? S_IDLE : S_PAYWAIT;
        end else if (tmo_q == TW'(DISP_TIMEOUT - 1)) begin
          state_d = S_FAULT;
          chg_d   = {CHG_W{1'b0}};
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_PAYWAIT: begin
        if (i_hopper_rdy) begin
          state_d = S_PAYHI;
          ph_d    = {CW{1'b0}};
        end else begin
          state_d = S_PAYWAIT;
        end
      end
      S_PAYHI: begin
        if (ph_q == CW'(PULSE_W - 1)) begin
          state_d = S_PAYLO;
          ph_d    = {CW{1'b0}};
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_PAYLO: begin
        if (ph_q == CW'(GAP_W - 1)) begin
          chg_d   = chg_q - 1'b1;
          ph_d    = {CW{1'b0}};
          state_d = (chg_q == CHG_W'(1)) ? S_IDLE : S_PAYWAIT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_FAULT: begin
        if (i_clr_fault) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO storage and registered outputs (outputs follow the next state).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {CHG_W{1'b0}};
      end
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {PW{1'b0}};
      chg_q        <= {CHG_W{1'b0}};
      tmo_q        <= {TW{1'b0}};
      ph_q         <= {CW{1'b0}};
      disp_start_q <= 1'b0;
      nickel_q     <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= i_change;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q      <= count_d;
      chg_q        <= chg_d;
      tmo_q        <= tmo_d;
      ph_q         <= ph_d;
      disp_start_q <= (state_d == S_DISPENSE) && (state_q != S_DISPENSE);
      nickel_q     <= (state_d == S_PAYHI);
      busy_q       <= (state_d != S_IDLE) || (count_d != {PW{1'b0}});
      fault_q      <= (state_d == S_FAULT);
      drop_q       <= drop_s;
    end
  end

  assign o_disp_start = disp_start_q;
  assign o_nickel     = nickel_q;
  assign o_busy       = busy_q;
  assign o_fault      = fault_q;
  assign o_drop       = drop_q;
  assign o_pending    = count_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: stimulus queues the coins expected per
// vend; a negedge monitor checks strobe counts and shapes per dispense.
module tb_vend_sequencer;

  localparam int PULSE_W = 2;
  localparam int GAP_W   = 2;

  logic       i_clk = 1'b0;
  logic       i_rst, i_vend, i_disp_done, i_hopper_rdy, i_clr_fault;
  logic [2:0] i_change;
  logic       o_disp_start, o_nickel, o_busy, o_fault, o_drop;
  logic [2:0] o_pending;

  vend_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vend(i_vend), .i_change(i_change),
    .i_disp_done(i_disp_done), .i_hopper_rdy(i_hopper_rdy), .i_clr_fault(i_clr_fault),
    .o_disp_start(o_disp_start), .o_nickel(o_nickel), .o_busy(o_busy),
    .o_fault(o_fault), .o_drop(o_drop), .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];
  int n_starts = 0, n_nick_hi = 0;
  bit active = 1'b0, nick_prev = 1'b0;
  int cur_exp = 0, nick_cnt = 0, hi_run = 0, lo_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_vend = 1'b0; i_change = 3'd0; i_disp_done = 1'b0;
    i_hopper_rdy = 1'b0; i_clr_fault = 1'b0;
    exp_q.delete();
    step();
    step();
    i_rst = 1'b0;
  endtask

  // Monitor: each coin after the first in an entry also passes one PAYWAIT cycle.
  always @(negedge i_clk) begin
    if (i_rst) begin
      active = 1'b0; nick_cnt = 0; hi_run = 0; lo_run = 0; nick_prev = 1'b0;
    end else begin
      if (o_nickel) begin
        n_nick_hi++;
        if (!nick_prev) begin
          nick_cnt++;
          if (nick_cnt > 1) chk("coin_gap", lo_run, GAP_W + 1);
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (nick_prev) chk("coin_width", hi_run, PULSE_W);
        hi_run = 0;
        lo_run++;
      end
      if (o_disp_start) begin
        n_starts++;
        if (active) chk("coins_per_vend", nick_cnt, cur_exp);
        chk("start_has_vend", int'(exp_q.size() != 0), 1);
        cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        active = 1'b1; nick_cnt = 0; lo_run = 0;
      end else if (active && !o_busy) begin
        chk("coins_per_vend", nick_cnt, cur_exp);
        active = 1'b0;
      end
      nick_prev = o_nickel;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, h0;

    // Test 1: reset state, then change=3 with done 5 cycles after start
    do_reset();
    chk("reset_outs", int'({o_disp_start, o_nickel, o_busy, o_fault, o_drop}), 0);
    chk("reset_pending", int'(o_pending), 0);
    i_hopper_rdy = 1'b1;
    s0 = n_starts;
    i_vend = 1'b1; i_change = 3'd3; exp_q.push_back(3);
    step();
    i_vend = 1'b0;
    chk("t1_pending_push", int'(o_pending), 1);
    chk("t1_busy", int'(o_busy), 1);
    step();
    chk("t1_pending_pop", int'(o_pending), 0);
    chk("t1_disp_start", int'(o_disp_start), 1);
    repeat (5) step();
    i_disp_done = 1'b1;
    step();
    i_disp_done = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin step(); n++; end
    chk("t1_busy_low_cycle", n, 15);
    step();
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Test 2: change=0 with done already high
    do_reset();
    i_hopper_rdy = 1'b1; i_disp_done = 1'b1;
    s0 = n_starts; h0 = n_nick_hi;
    i_vend = 1'b1; i_change = 3'd0; exp_q.push_back(0);
    step();
    i_vend = 1'b0;
    step();
    chk("t2_disp_start", int'(o_disp_start), 1);
    step();
    chk("t2_idle", int'({o_busy, o_disp_start}), 0);
    repeat (3) step();
    chk("t2_starts", n_starts - s0, 1);
    chk("t2_no_nickel", n_nick_hi - h0, 0);

    // Test 3: six back-to-back vends while the dispenser never answers
    do_reset();
    for (int i = 0; i < 6; i++) begin
      automatic int exp_pend[6] = '{1, 1, 2, 3, 4, 4};
      i_vend = 1'b1; i_change = 3'(i + 1);
      if (i < 5) exp_q.push_back(i + 1);
      step();
      chk("t3_pending", int'(o_pending), exp_pend[i]);
      chk("t3_drop", int'(o_drop), (i == 5) ? 1 : 0);
    end
    i_vend = 1'b0;
    step();
    chk("t3_drop_once", int'(o_drop), 0);
    chk("t3_pending_sat", int'(o_pending), 4);

    // Test 4: timeout to FAULT, queueing during FAULT, clear, faulted change dropped
    do_reset();
    i_hopper_rdy = 1'b1;
    s0 = n_starts;
    i_vend = 1'b1; i_change = 3'd5; exp_q.push_back(0);
    step();
    i_change = 3'd2; exp_q.push_back(2);
    step();
    i_vend = 1'b0;
    chk("t4_disp_start", int'(o_disp_start), 1);
    i_clr_fault = 1'b1;
    step();
    i_clr_fault = 1'b0;
    n = 1;
    while (!o_fault && n < 400) begin step(); n++; end
    chk("t4_fault_cycle", n, 255);
    i_vend = 1'b1; i_change = 3'd1; exp_q.push_back(1);
    step();
    i_vend = 1'b0;
    chk("t4_pending_in_fault", int'(o_pending), 2);
    repeat (3) step();
    chk("t4_fault_held", int'(o_fault), 1);
    chk("t4_starts_in_fault", n_starts - s0, 1);
    i_clr_fault = 1'b1;
    step();
    i_clr_fault = 1'b0;
    chk("t4_fault_cleared", int'(o_fault), 0);
    i_disp_done = 1'b1;
    n = 0;
    while (o_busy && n < 200) begin step(); n++; end
    chk("t4_drained", int'(o_busy), 0);
    step();
    chk("t4_pending_end", int'(o_pending), 0);
    chk("t4_starts", n_starts - s0, 3);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Test 5: hopper not ready for 10 PAYWAIT cycles, change=2
    do_reset();
    i_disp_done = 1'b1;
    i_vend = 1'b1; i_change = 3'd2; exp_q.push_back(2);
    step();
    i_vend = 1'b0;
    step();
    chk("t5_disp_start", int'(o_disp_start), 1);
    h0 = n_nick_hi;
    repeat (10) step();
    chk("t5_no_nickel_wait", n_nick_hi - h0, 0);
    i_hopper_rdy = 1'b1;
    n = 0;
    while (o_busy && n < 100) begin step(); n++; end
    chk("t5_done", int'(o_busy), 0);
    step();
    chk("t5_nickels", n_nick_hi - h0, 2 * PULSE_W);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Test 6: reset mid-PAYHI with two entries queued
    do_reset();
    i_hopper_rdy = 1'b1; i_disp_done = 1'b1;
    exp_q.push_back(3);
    for (int i = 0; i < 3; i++) begin
      i_vend = 1'b1; i_change = 3'(i + 3);
      step();
    end
    i_vend = 1'b0;
    n = 0;
    while (!o_nickel && n < 50) begin step(); n++; end
    chk("t6_in_payhi", int'(o_nickel), 1);
    chk("t6_pending_before", int'(o_pending), 2);
    i_rst = 1'b1;
    exp_q.delete();
    step();
    chk("t6_outs_after_rst", int'({o_disp_start, o_nickel, o_busy, o_fault, o_drop}), 0);
    chk("t6_pending_after_rst", int'(o_pending), 0);
    i_rst = 1'b0;
    s0 = n_starts; h0 = n_nick_hi;
    repeat (30) step();
    chk("t6_no_strobes", n_nick_hi - h0, 0);
    chk("t6_no_starts", n_starts - s0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
